// File: rtl/rpn_calc_ctrl.sv
// Reverse-Polish token controller sitting in front of a LIFO stack.
// It sequences push/pop strobes to evaluate add/sub/mul/peek and reports stack errors.
module rpn_calc_ctrl #(
   parameter int B = 8,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tok_valid,
   output logic         tok_ready,
   input  logic         tok_is_op,
   input  logic [B-1:0] tok_data,
   output logic         push,
   output logic         pop,
   output logic [B-1:0] wr_data,
   input  logic [B-1:0] rd_data,
   input  logic         empty,
   input  logic         full,
   output logic [B-1:0] result,
   output logic         result_valid,
   output logic         err,
   output logic [1:0]   err_code
);

   // A binary operator needs at least two stack entries, so the stack must be deeper than one.
   if (W < 1) begin : g_bad_w
      $error("rpn_calc_ctrl: W must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE, PUSH_OP, POP_B, POP_A, RESTORE, PUSH_R, SHOW
   } state_t;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_PEEK = 2'b11;
   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UNF  = 2'b10;

   state_t         state_q, state_d;
   logic [B-1:0]   wr_q, wr_d;
   logic [B-1:0]   opa_q, opa_d;
   logic [B-1:0]   opb_q, opb_d;
   logic [1:0]     op_q, op_d;
   logic [B-1:0]   result_q, result_d;
   logic           result_valid_q, result_valid_d;
   logic           err_q, err_d;
   logic [1:0]     err_code_q, err_code_d;
   logic [B-1:0]   alu_out;

   // All results wrap modulo 2**B; multiplication keeps only the low word.
   function automatic logic [B-1:0] alu(input logic [1:0] op,
                                        input logic [B-1:0] a,
                                        input logic [B-1:0] b);
      logic [2*B-1:0] prod;
      prod = a * b;
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         default: return prod[B-1:0];
      endcase
   endfunction

   assign alu_out = alu(op_q, opa_q, opb_q);

   always_comb begin
      state_d        = state_q;
      wr_d           = wr_q;
      opa_d          = opa_q;
      opb_d          = opb_q;
      op_d           = op_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      err_d          = 1'b0;
      err_code_d     = err_code_q;
      case (state_q)
         IDLE: begin
            if (tok_valid) begin
               err_code_d = ERR_NONE;
               if (!tok_is_op) begin
                  if (full) begin
                     err_d      = 1'b1;
                     err_code_d = ERR_OVF;
                  end else begin
                     wr_d    = tok_data;
                     state_d = PUSH_OP;
                  end
               end else begin
                  op_d    = tok_data[1:0];
                  state_d = (tok_data[1:0] == OP_PEEK) ? SHOW : POP_B;
               end
            end
         end
         PUSH_OP: state_d = IDLE;
         POP_B: begin
            if (empty) begin
               err_d      = 1'b1;
               err_code_d = ERR_UNF;
               state_d    = IDLE;
            end else begin
               opb_d   = rd_data;
               state_d = POP_A;
            end
         end
         POP_A: begin
            // Only one operand was available: put it back so the stack is unchanged.
            if (empty) begin
               err_d      = 1'b1;
               err_code_d = ERR_UNF;
               wr_d       = opb_q;
               state_d    = RESTORE;
            end else begin
               opa_d   = rd_data;
               state_d = PUSH_R;
            end
         end
         RESTORE: state_d = IDLE;
         PUSH_R: begin
            result_d       = alu_out;
            result_valid_d = 1'b1;
            state_d        = IDLE;
         end
         SHOW: begin
            if (empty) begin
               err_d      = 1'b1;
               err_code_d = ERR_UNF;
            end else begin
               result_d       = rd_data;
               result_valid_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         wr_q           <= '0;
         opa_q          <= '0;
         opb_q          <= '0;
         op_q           <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         err_q          <= 1'b0;
         err_code_q     <= ERR_NONE;
      end else begin
         state_q        <= state_d;
         wr_q           <= wr_d;
         opa_q          <= opa_d;
         opb_q          <= opb_d;
         op_q           <= op_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         err_q          <= err_d;
         err_code_q     <= err_code_d;
      end
   end

   // Stack strobes are decoded from registered state; pops are gated by the registered empty flag.
   assign tok_ready    = (state_q == IDLE);
   assign push         = (state_q == PUSH_OP) || (state_q == RESTORE) || (state_q == PUSH_R);
   assign pop          = ((state_q == POP_B) || (state_q == POP_A)) && !empty;
   assign wr_data      = (state_q == PUSH_R) ? alu_out : wr_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign err          = err_q;
   assign err_code     = err_code_q;

endmodule

// File: tb/tb_rpn_calc_ctrl.sv
// Bench for rpn_calc_ctrl: a LIFO stack model supplies rd_data/empty/full, and a queue-based
// RPN reference predicts results, errors, latencies and stack contents for every token.
module tb_rpn_calc_ctrl;
   localparam int B = 8;
   localparam int W = 4;
   localparam int DEPTH = 1 << W;
   localparam int MASK = (1 << B) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         tok_valid;
   logic         tok_ready;
   logic         tok_is_op;
   logic [B-1:0] tok_data;
   logic         push;
   logic         pop;
   logic [B-1:0] wr_data;
   logic [B-1:0] rd_data;
   logic         empty;
   logic         full;
   logic [B-1:0] result;
   logic         result_valid;
   logic         err;
   logic [1:0]   err_code;

   always #5 clk = ~clk;

   rpn_calc_ctrl #(.B(B), .W(W)) dut (
      .clk(clk), .rst(rst),
      .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
      .push(push), .pop(pop), .wr_data(wr_data),
      .rd_data(rd_data), .empty(empty), .full(full),
      .result(result), .result_valid(result_valid), .err(err), .err_code(err_code)
   );

   // Stack model shared with the controller's clock and reset
   logic [B-1:0] mem [DEPTH];
   int sp = 0;
   int n_push = 0, n_pop = 0, n_bad = 0;

   always @(posedge clk) begin
      if (rst) begin
         sp <= 0;
      end else begin
         if (push && !pop && sp < DEPTH) begin
            mem[sp] <= wr_data;
            sp <= sp + 1;
         end else if (pop && !push && sp > 0) begin
            sp <= sp - 1;
         end
         if (push) n_push <= n_push + 1;
         if (pop) n_pop <= n_pop + 1;
         if ((push && pop) || (push && sp == DEPTH) || (pop && sp == 0)) n_bad <= n_bad + 1;
      end
   end

   assign empty   = (sp == 0);
   assign full    = (sp == DEPTH);
   assign rd_data = (sp > 0) ? mem[sp-1] : '0;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   // Reference state: stack contents, last result and held error code
   int ref_stk[$];
   int ref_result = 0;
   int ref_code = 0;

   task automatic do_reset();
      rst = 1'b1;
      tok_valid = 1'b0;
      tok_is_op = 1'b0;
      tok_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ref_stk.delete();
      ref_result = 0;
      ref_code = 0;
   endtask

   task automatic check_idle_clean(input string pfx);
      check_eq({pfx, "_ready"}, int'(tok_ready), 1);
      check_eq({pfx, "_push"}, int'(push), 0);
      check_eq({pfx, "_pop"}, int'(pop), 0);
      check_eq({pfx, "_result"}, int'(result), 0);
      check_eq({pfx, "_rvalid"}, int'(result_valid), 0);
      check_eq({pfx, "_err"}, int'(err), 0);
      check_eq({pfx, "_err_code"}, int'(err_code), 0);
   endtask

   task automatic run_token(input string tag, input logic is_op, input logic [B-1:0] data);
      int e_lat, e_rv, e_res, e_errs, e_push, e_pop;
      int lat, rv, res, errs, p0, q0, guard, a, b;
      e_lat = 0; e_rv = 0; e_res = 0; e_errs = 0; e_push = 0; e_pop = 0;
      // Reference prediction from the RPN rules and the stated latencies
      ref_code = 0;
      if (!is_op) begin
         if (ref_stk.size() == DEPTH) begin
            e_lat = 1; e_errs = 1; ref_code = 1;
         end else begin
            ref_stk.push_back(int'(data));
            e_lat = 2; e_push = 1;
         end
      end else if (data[1:0] == 2'b11) begin
         e_lat = 2;
         if (ref_stk.size() == 0) begin
            e_errs = 1; ref_code = 2;
         end else begin
            e_rv = 1; e_res = ref_stk[$];
         end
      end else if (ref_stk.size() == 0) begin
         e_lat = 2; e_errs = 1; ref_code = 2;
      end else if (ref_stk.size() == 1) begin
         e_lat = 4; e_errs = 1; ref_code = 2; e_push = 1; e_pop = 1;
      end else begin
         b = ref_stk.pop_back();
         a = ref_stk.pop_back();
         case (data[1:0])
            2'b00:   e_res = (a + b) & MASK;
            2'b01:   e_res = (a - b) & MASK;
            default: e_res = (a * b) & MASK;
         endcase
         ref_stk.push_back(e_res);
         e_lat = 4; e_rv = 1; e_push = 1; e_pop = 2;
      end
      if (e_rv != 0) ref_result = e_res;

      guard = 0;
      while (!tok_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!tok_ready) check_eq({tag, "_ready_wait"}, 0, 1);
      p0 = n_push;
      q0 = n_pop;
      tok_valid = 1'b1;
      tok_is_op = is_op;
      tok_data = data;
      @(posedge clk);
      #1 tok_valid = 1'b0;

      lat = 0; rv = 0; res = -1; errs = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (result_valid) begin
            rv++;
            res = int'(result);
         end
         if (err) errs++;
         if (tok_ready) begin
            lat = k;
            break;
         end
         // Junk tokens while busy must be ignored
         tok_valid = 1'($urandom_range(0, 1));
         tok_is_op = 1'($urandom_range(0, 1));
         tok_data = B'($urandom);
      end
      tok_valid = 1'b0;

      check_eq({tag, "_latency"}, lat, e_lat);
      check_eq({tag, "_rvalid_cnt"}, rv, e_rv);
      if (e_rv != 0) check_eq({tag, "_result"}, res, e_res);
      check_eq({tag, "_err_cnt"}, errs, e_errs);
      check_eq({tag, "_err_code"}, int'(err_code), ref_code);
      check_eq({tag, "_result_hold"}, int'(result), ref_result);
      check_eq({tag, "_push_cnt"}, n_push - p0, e_push);
      check_eq({tag, "_pop_cnt"}, n_pop - q0, e_pop);
      check_eq({tag, "_depth"}, sp, ref_stk.size());
      if (ref_stk.size() > 0) check_eq({tag, "_top"}, int'(rd_data), ref_stk[$]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [B-1:0] v;
      int guard;
      do_reset();
      @(negedge clk);
      check_idle_clean("reset");
      check_eq("reset_wr_data", int'(wr_data), 0);

      // Basic arithmetic
      run_token("push5", 1'b0, 8'd5);
      run_token("push3", 1'b0, 8'd3);
      run_token("add", 1'b1, 8'd0);
      run_token("push9", 1'b0, 8'd9);
      run_token("push4", 1'b0, 8'd4);
      run_token("sub_pos", 1'b1, 8'd1);
      run_token("push4b", 1'b0, 8'd4);
      run_token("push9b", 1'b0, 8'd9);
      run_token("sub_neg", 1'b1, 8'd1);
      run_token("push20", 1'b0, 8'd20);
      run_token("push20b", 1'b0, 8'd20);
      run_token("mul", 1'b1, 8'd2);

      // Single operand: restore path, then peek
      do_reset();
      run_token("push7", 1'b0, 8'd7);
      run_token("add_unf", 1'b1, 8'd0);
      run_token("peek7", 1'b1, 8'd3);

      // Empty stack operators
      do_reset();
      run_token("peek_empty", 1'b1, 8'd3);
      run_token("add_empty", 1'b1, 8'd0);

      // Fill to overflow
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         v = B'($urandom_range(1, 100));
         run_token("fill", 1'b0, v);
      end
      check_eq("full_flag", int'(full), 1);
      run_token("overflow", 1'b0, 8'd55);
      run_token("add_after_full", 1'b1, 8'd0);

      // Reset while in POP_A
      guard = 0;
      while (!tok_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      tok_valid = 1'b1;
      tok_is_op = 1'b1;
      tok_data = 8'd0;
      @(posedge clk);
      #1 tok_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("midrst_popa_pop", int'(pop), 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      ref_stk.delete();
      ref_result = 0;
      ref_code = 0;
      @(negedge clk);
      check_idle_clean("midrst");

      // Randomized token stream
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 55) run_token("rnd_operand", 1'b0, B'($urandom));
         else run_token("rnd_operator", 1'b1, B'($urandom));
      end

      check_eq("stack_protocol_violations", n_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/rpn_calc_ctrl.md
Name: rpn_calc_ctrl

Overview:
Reverse-Polish evaluator front end that sits directly upstream of the LIFO stack block. It accepts a stream of operand/operator tokens over a valid/ready handshake. It drives the stack's push, pop and wr_data inputs, and consumes the stack's rd_data, empty and full outputs. Results are presented on a registered result port with a one-cycle valid strobe; stack overflow and underflow are reported as error codes.

Parameters:
B, 8, data width of operands, results and stack words
W, 4, stack address width; stack depth is 2**W (informational, not used in logic)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
tok_valid  input  1  token present on tok_is_op/tok_data
tok_ready  output  1  controller can accept a token this cycle
tok_is_op  input  1  1 = operator token, 0 = operand token
tok_data  input  B  operand value; when tok_is_op=1, bits [1:0] = opcode (00 add, 01 sub, 10 mul, 11 peek)
push  output  1  stack push strobe
pop  output  1  stack pop strobe
wr_data  output  B  data to stack on push
rd_data  input  B  stack top-of-stack, combinational read
empty  input  1  stack empty flag, registered in stack
full  input  1  stack full flag, registered in stack
result  output  B  last computed or peeked value
result_valid  output  1  one-cycle strobe, result updated
err  output  1  one-cycle error strobe
err_code  output  2  00 none, 01 overflow, 10 underflow; held until next accepted token

Behaviour:
- Reset: clk and rst are shared with the stack. The controller is synchronous, active-high; on rst, state=IDLE, push=pop=0, wr_data=0, result=0, result_valid=0, err=0, err_code=00, opa=opb=0. Reset mid-operation abandons the sequence with no further strobes.
- Stack contract:
  - push/pop take effect on the clock edge at which they are high.
  - rd_data, empty and full reflect the new stack state from the next cycle.
  - push and pop are never asserted in the same cycle.
- push, pop and wr_data are Moore outputs decoded from registered state/data.
- tok_ready = 1 only in IDLE. A token is accepted on a cycle with tok_valid & tok_ready. err_code clears to 00 on acceptance.
- States:
  - IDLE: on an accepted operand: if full, err strobe and err_code=01, stay IDLE, no push; else latch tok_data into wr_data and go to PUSH_OP. On an accepted operator: latch the opcode; peek goes to SHOW, others go to POP_B.
  - PUSH_OP: push=1, then IDLE.
  - POP_B: if empty, err=1 and err_code=10, then IDLE (stack untouched). Else opb<=rd_data, pop=1, then POP_A.
  - POP_A: if empty, err_code=10, then RESTORE. Else opa<=rd_data, pop=1, then PUSH_R.
  - RESTORE: wr_data=opb, push=1, err=1, then IDLE. The stack is left exactly as before the operator.
  - PUSH_R: wr_data = f(opa, opb), push=1; result<=same value, result_valid=1 on the following cycle; then IDLE.
  - SHOW: if empty, err=1 and err_code=10; else result<=rd_data, result_valid=1 the following cycle, no pop. Then IDLE.
- Arithmetic: add = opa+opb, sub = opa-opb (opa is the deeper operand), mul = low B bits of opa*opb. All results are modulo 2**B; no carry or overflow flag.
- Latency from accept edge T:
  - Operand push at T+1; tok_ready high again at T+2.
  - Binary op: pops at T+1 and T+2, push at T+3, result_valid at T+4 with tok_ready=1.
  - Peek: result_valid at T+2.
- Result push cannot overflow, since two entries were removed first.
- tok_ready stays low throughout any multi-cycle sequence; tok_valid is ignored outside IDLE.

Test Plan:
- rst; push 5, push 3, op add -> pops at T+1/T+2, push wr_data=8 at T+3, result=8 with result_valid pulse at T+4; stack depth 1.
- Push 9, push 4, op sub -> result=5; push 4, push 9, op sub -> result=0xFB; push 20, push 20, op mul -> result=0x90.
- rst; push 7, op add -> one pop, RESTORE pushes 7, err pulse, err_code=10; then peek -> result=7, err_code=00.
- rst; op peek and op add on empty stack -> err pulse, err_code=10, no push/pop strobes ever asserted.
- 16 operand pushes until full=1; 17th operand -> err, err_code=01, no push; op add then yields the sum of the top two, mod 256.
- Assert rst in POP_A mid-operator -> next cycle state IDLE, all strobes 0, result=0, err_code=00, tok_ready=1.
